// File: rtl/frame_timer_pkg.sv
// Shared constants and types for the frame timer bank: channel modes,
// channel state encoding and the prescaler divide helper.
package frame_timer_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  function automatic int calc_div(input int clock_hz, input int frame_hz);
    return clock_hz / frame_hz;
  endfunction

endpackage

// File: rtl/frame_timer_channel.sv
// One frame-count timer channel: latched period/mode, remaining count,
// IDLE/RUN state and a registered one-cycle done pulse.
module frame_timer_channel
  import frame_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             pause,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output ch_state_t        state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] period_q;
  logic             mode_q;

  // Priority: stop, then start (a zero-period start is dropped and the
  // channel holds that cycle), then tick-driven countdown.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      count    <= '0;
      done     <= 1'b0;
      period_q <= '0;
      mode_q   <= MODE_PERIODIC;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        count <= '0;
      end else if (start) begin
        if (period != '0) begin
          period_q <= period;
          mode_q   <= mode;
          count    <= period;
          state    <= ST_RUN;
        end
      end else if (state == ST_RUN && tick && !pause) begin
        if (count > ONE) begin
          count <= count - ONE;
        end else begin
          done <= 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            count <= '0;
            state <= ST_IDLE;
          end else begin
            count <= period_q;
          end
        end
      end
    end
  end

endmodule

// File: rtl/frame_timer_bank.sv
// Shared frame prescaler driving a bank of independent frame-count timers.
// Control strobes are sampled at each rising edge; there is no handshake.
module frame_timer_bank
  import frame_timer_pkg::*;
#(
  parameter int CLOCK_HZ = 50000000,
  parameter int FRAME_HZ = 60,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    frame_enable,
  input  logic                    frame_sync,
  output logic                    frame_tick,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH-1:0]       ch_pause,
  input  logic [NUM_CH*CNT_W-1:0] ch_period,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_done
);

  localparam int DIV   = calc_div(CLOCK_HZ, FRAME_HZ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("frame_timer_bank: CLOCK_HZ/FRAME_HZ must be at least 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_check
    $error("frame_timer_bank: NUM_CH must be in 1..16");
  end

  logic [DIV_W-1:0] pre_cnt;

  // frame_sync wins over frame_enable; the tick lands one cycle after
  // the counter wraps, so ticks are exactly DIV enabled cycles apart.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre_cnt    <= '0;
      frame_tick <= 1'b0;
    end else if (frame_sync) begin
      pre_cnt    <= '0;
      frame_tick <= 1'b0;
    end else if (frame_enable) begin
      if (pre_cnt == DIV_LAST) begin
        pre_cnt    <= '0;
        frame_tick <= 1'b1;
      end else begin
        pre_cnt    <= pre_cnt + DIV_W'(1);
        frame_tick <= 1'b0;
      end
    end else begin
      frame_tick <= 1'b0;
    end
  end

  ch_state_t ch_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    frame_timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock  (clock),
      .resetn (resetn),
      .tick   (frame_tick),
      .start  (ch_start[i]),
      .stop   (ch_stop[i]),
      .mode   (ch_mode[i]),
      .pause  (ch_pause[i]),
      .period (ch_period[i*CNT_W +: CNT_W]),
      .count  (ch_count[i*CNT_W +: CNT_W]),
      .done   (ch_done[i]),
      .state  (ch_state[i])
    );
    assign ch_busy[i] = (ch_state[i] == ST_RUN);
  end

endmodule
